alu_seq_core: RTL and testbench

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

---
 rtl/alu_seq_core.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU with a serially loaded 3-bit opcode.
// Single-cycle ops finish one edge after acceptance. MUL is an iterative
// shift-add that finishes WIDTH edges after acceptance.
module alu_seq_core #(
    parameter int unsigned WIDTH = 6
) (
    input  logic               clk,
    input  logic               reset_all,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               instruction_in,
    input  logic               inst_load_en,
    input  logic               reset_instr,
    input  logic               start,
    output logic               opcode_ready,
    output logic               busy,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_ACC = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MULT = 2'd2
    } state_e;

    // opcode loader state
    logic [2:0]       op_q, op_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;

    // control and execution state
    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    op_e              xop_q, xop_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    mcnt_q, mcnt_d;
    logic [RW-1:0]    mcand_q, mcand_d;
    logic [RW-1:0]    prod_q, prod_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    // combinational helpers
    logic             accept_c;
    logic [WIDTH:0]   add_sum_c;
    logic [WIDTH-1:0] sub_diff_c;
    logic [RW:0]      acc_sum_c;
    logic [RW-1:0]    a_ext_c;
    logic [RW-1:0]    shl_c;
    logic [RW-1:0]    exec_res_c;
    logic             exec_carry_c;
    logic [RW-1:0]    prod_next_c;

    // Serial opcode shift register with a counter that saturates at 3
    always_comb begin
        op_d  = op_q;
        cnt_d = cnt_q;
        if (reset_instr) begin
            op_d  = 3'b000;
            cnt_d = 2'd0;
        end else if (inst_load_en) begin
            op_d = {op_q[1:0], instruction_in};
            if (cnt_q != 2'd3) begin
                cnt_d = cnt_q + 2'd1;
            end
        end
        ready_d = (cnt_d == 2'd3);
    end

    // Start is honoured only with a full opcode, an idle core and no load in progress
    assign accept_c = start && ready_q && (state_q == ST_IDLE) && !inst_load_en;

    // Single-cycle datapath on the latched operands
    always_comb begin
        add_sum_c    = {1'b0, a_q} + {1'b0, b_q};
        sub_diff_c   = a_q - b_q;
        acc_sum_c    = {1'b0, acc_q} + (RW + 1)'(a_q);
        a_ext_c      = RW'(a_q);
        shl_c        = (32'(b_q) >= RW) ? '0 : (a_ext_c << b_q);
        exec_res_c   = '0;
        exec_carry_c = 1'b0;
        case (xop_q)
            OP_ADD: begin
                exec_res_c   = RW'(add_sum_c);
                exec_carry_c = add_sum_c[WIDTH];
            end
            OP_SUB: begin
                exec_res_c   = RW'(sub_diff_c);
                exec_carry_c = (a_q < b_q);
            end
            OP_AND: exec_res_c = RW'(a_q & b_q);
            OP_OR:  exec_res_c = RW'(a_q | b_q);
            OP_XOR: exec_res_c = RW'(a_q ^ b_q);
            OP_SHL: exec_res_c = shl_c;
            OP_ACC: begin
                exec_res_c   = acc_sum_c[RW-1:0];
                exec_carry_c = acc_sum_c[RW];
            end
            default: begin
                exec_res_c   = '0;
                exec_carry_c = 1'b0;
            end
        endcase
    end

    // One shift-add partial product per MULT cycle; b_q is consumed LSB first
    assign prod_next_c = prod_q + (b_q[0] ? mcand_q : '0);

    // FSM next-state and execution register updates
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        xop_d    = xop_q;
        a_d      = a_q;
        b_d      = b_q;
        mcnt_d   = mcnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    a_d    = A;
                    b_d    = B;
                    xop_d  = op_e'(op_q);
                    busy_d = 1'b1;
                    if (op_e'(op_q) == OP_MUL) begin
                        state_d = ST_MULT;
                        mcnt_d  = '0;
                        mcand_d = RW'(A);
                        prod_d  = '0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                valid_d  = 1'b1;
                result_d = exec_res_c;
                carry_d  = exec_carry_c;
                zero_d   = (exec_res_c == '0);
                if (xop_q == OP_ACC) begin
                    acc_d = acc_sum_c[RW-1:0];
                end
            end
            ST_MULT: begin
                prod_d  = prod_next_c;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                mcnt_d  = mcnt_q + CW'(1);
                if (mcnt_q == CW'(WIDTH - 1)) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    valid_d  = 1'b1;
                    result_d = prod_next_c;
                    carry_d  = 1'b0;
                    zero_d   = (prod_next_c == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset_all clears everything immediately
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            op_q     <= 3'b000;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b0;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            xop_q    <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            mcnt_q   <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            xop_q    <= xop_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcnt_q   <= mcnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign opcode_ready = ready_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign carry        = carry_q;
    assign zero         = zero_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=6.
module tb_alu_seq_core;

    localparam int unsigned W = 6;

    logic           clk = 1'b0;
    logic           reset_all = 1'b1;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           instruction_in = 1'b0;
    logic           inst_load_en = 1'b0;
    logic           reset_instr = 1'b0;
    logic           start = 1'b0;
    logic           opcode_ready;
    logic           busy;
    logic           result_valid;
    logic [2*W-1:0] result;
    logic           carry;
    logic           zero;

    int n_total = 0;
    int n_bad   = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset_all      (reset_all),
        .A              (A),
        .B              (B),
        .instruction_in (instruction_in),
        .inst_load_en   (inst_load_en),
        .reset_instr    (reset_instr),
        .start          (start),
        .opcode_ready   (opcode_ready),
        .busy           (busy),
        .result_valid   (result_valid),
        .result         (result),
        .carry          (carry),
        .zero           (zero)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bit(input logic b);
        inst_load_en   = 1'b1;
        instruction_in = b;
        tick();
        inst_load_en   = 1'b0;
    endtask

    task automatic load3(input logic b2, input logic b1, input logic b0);
        load_bit(b2);
        load_bit(b1);
        load_bit(b0);
    endtask

    // Issue a single-cycle op and check the completion cycle
    task automatic run_single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int exp_res, input int exp_cry);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_res"}, 32'(result), 32'(exp_res));
        check({tag, "_carry"}, 32'(carry), 32'(exp_cry));
        check({tag, "_zero"}, 32'(zero), (exp_res == 0) ? 32'd1 : 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_ready", 32'(opcode_ready), 32'd0);
        reset_all = 1'b0;
        tick();

        // ADD with carry out, ready only after the third bit
        load_bit(1'b0);
        load_bit(1'b0);
        check("ready_2bits", 32'(opcode_ready), 32'd0);
        load_bit(1'b0);
        check("ready_3bits", 32'(opcode_ready), 32'd1);
        run_single("add", 6'd63, 6'd1, 64, 1);
        tick();
        check("add_valid_drop", 32'(result_valid), 32'd0);
        check("add_hold", 32'(result), 32'd64);

        // SUB with borrow, then back-to-back SUB to zero
        load3(1'b0, 1'b0, 1'b1);
        check("ready_sat", 32'(opcode_ready), 32'd1);
        run_single("sub", 6'd5, 6'd7, 62, 1);
        run_single("sub0", 6'd7, 6'd7, 0, 0);

        // logic ops and shifts
        load3(1'b0, 1'b1, 1'b0);
        run_single("and", 6'd44, 6'd26, 8, 0);
        load3(1'b0, 1'b1, 1'b1);
        run_single("or", 6'd44, 6'd26, 62, 0);
        load3(1'b1, 1'b0, 1'b0);
        run_single("xor", 6'd44, 6'd26, 54, 0);
        load3(1'b1, 1'b1, 1'b0);
        run_single("shl6", 6'd63, 6'd6, 4032, 0);
        run_single("shl11", 6'd63, 6'd11, 2048, 0);
        run_single("shl12", 6'd63, 6'd12, 0, 0);
        run_single("shl63", 6'd1, 6'd63, 0, 0);

        // MUL 63*63, start held high while busy must be ignored
        load3(1'b1, 1'b0, 1'b1);
        A     = 6'd63;
        B     = 6'd63;
        start = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("mul_busy%0d", i), 32'(busy), 32'd1);
            check($sformatf("mul_novalid%0d", i), 32'(result_valid), 32'd0);
            if (i == 4) start = 1'b0;
            tick();
        end
        check("mul_res", 32'(result), 32'd3969);
        check("mul_valid", 32'(result_valid), 32'd1);
        check("mul_idle", 32'(busy), 32'd0);
        check("mul_carry", 32'(carry), 32'd0);
        tick();
        check("mul_valid_drop", 32'(result_valid), 32'd0);
        check("mul_no_restart", 32'(busy), 32'd0);

        // start with only two opcode bits is ignored
        reset_instr = 1'b1;
        tick();
        reset_instr = 1'b0;
        check("rinstr_ready", 32'(opcode_ready), 32'd0);
        load_bit(1'b1);
        load_bit(1'b0);
        A     = 6'd5;
        B     = 6'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_2bits", 32'(busy), 32'd0);
        check("start_2bits_res", 32'(result), 32'd3969);

        // MUL survives reset_instr and operand changes in flight
        load_bit(1'b1);
        check("ready_mul2", 32'(opcode_ready), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = 6'd0;
        B     = 6'd0;
        check("mul2_busy", 32'(busy), 32'd1);
        tick();
        reset_instr = 1'b1;
        tick();
        reset_instr = 1'b0;
        check("mul2_ready_clr", 32'(opcode_ready), 32'd0);
        check("mul2_still_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        check("mul2_busy_e5", 32'(busy), 32'd1);
        tick();
        check("mul2_res", 32'(result), 32'd45);
        check("mul2_valid", 32'(result_valid), 32'd1);
        check("mul2_ready_after", 32'(opcode_ready), 32'd0);

        // ACC accumulates across starts
        load3(1'b1, 1'b1, 1'b1);
        run_single("acc1", 6'd40, 6'd0, 40, 0);
        run_single("acc2", 6'd40, 6'd0, 80, 0);
        run_single("acc3", 6'd40, 6'd0, 120, 0);

        // asynchronous reset in the middle of a MUL
        load3(1'b1, 1'b0, 1'b1);
        A     = 6'd3;
        B     = 6'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset_all = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_zero", 32'(zero), 32'd1);
        check("arst_carry", 32'(carry), 32'd0);
        check("arst_ready", 32'(opcode_ready), 32'd0);
        check("arst_valid", 32'(result_valid), 32'd0);
        tick();
        reset_all = 1'b0;
        tick();
        check("arst_ready_after", 32'(opcode_ready), 32'd0);
        check("arst_no_complete", 32'(result_valid), 32'd0);

        // accumulator was cleared by reset
        load3(1'b1, 1'b1, 1'b1);
        run_single("acc_post_rst", 6'd1, 6'd0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
